// File: rtl/wb_pkg.sv
// Shared types and defaults for the register-file writeback arbiter.
package wb_pkg;

    localparam int WB_DEPTH_DEFAULT    = 4;
    localparam int WB_MAX_WAIT_DEFAULT = 8;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_entry_t;

    // One-hot register select used to build the pending-write mask.
    function automatic logic [31:0] rd_onehot(input logic [4:0] rd);
        return 32'(1) << rd;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Circular FIFO of buffered FP results. Exposes per-slot valid/rd so the
// parent can build a pending-write mask without walking the pointers.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = WB_DEPTH_DEFAULT
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  wb_entry_t                push_entry,
    input  logic                     pop,
    output wb_entry_t                head,
    output logic [$clog2(DEPTH):0]   count,
    output logic [DEPTH-1:0]         slot_valid,
    output logic [DEPTH-1:0][4:0]    slot_rd
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    wb_entry_t      mem [DEPTH];
    logic [PW-1:0]  rd_ptr;
    logic [PW-1:0]  wr_ptr;

    assign head = mem[rd_ptr];

    // A slot is live when its distance from the read pointer is below count.
    for (genvar i = 0; i < DEPTH; i++) begin : g_slot
        logic [PW-1:0] offset;
        assign offset        = PW'(i) - rd_ptr;
        assign slot_valid[i] = {1'b0, offset} < count;
        assign slot_rd[i]    = mem[i].rd;
    end

    // Pointer, occupancy and storage updates; push and pop may coincide.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_entry;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/regfile_writeback_arbiter.sv
// Single write-port arbiter for the FP register file. In-order pipeline
// writebacks take priority; FP unit results queue in wb_fifo and drain in
// idle slots. Optional macro WB_FP_BYPASS_EN lets an FP result skip the
// empty FIFO and reach the write port in one edge.
module regfile_writeback_arbiter
    import wb_pkg::*;
#(
    parameter int DEPTH    = WB_DEPTH_DEFAULT,
    parameter int MAX_WAIT = WB_MAX_WAIT_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        halt,
    input  logic        pipe_valid,
    input  logic [4:0]  pipe_rd,
    input  logic [31:0] pipe_data,
    input  logic        fp_valid,
    output logic        fp_ready,
    input  logic [4:0]  fp_rd,
    input  logic [31:0] fp_data,
    output logic        register_write_enable,
    output logic [4:0]  destination_register,
    output logic [31:0] value_to_write_to_reg,
    output logic [31:0] fp_pending_mask,
    output logic        wb_stall_req,
    output logic        wb_waw_error
);

    localparam int CW = $clog2(DEPTH) + 1;

    wb_entry_t               head;
    wb_entry_t               push_entry;
    logic [CW-1:0]           count;
    logic [DEPTH-1:0]        slot_valid;
    logic [DEPTH-1:0][4:0]   slot_rd;
    logic                    fifo_empty;
    logic                    fp_keep;
    logic                    bypass;
    logic                    push;
    logic                    pop;
    logic [7:0]              wait_cnt;

    assign fifo_empty = (count == '0);
    assign fp_ready   = (count != CW'(DEPTH));

    // Register 0 results complete the handshake but are thrown away.
    assign fp_keep = fp_valid && fp_ready && (fp_rd != 5'd0);

`ifdef WB_FP_BYPASS_EN
    assign bypass = fp_keep && fifo_empty && !pipe_valid && !halt;
`else
    assign bypass = 1'b0;
`endif

    assign push       = fp_keep && !bypass;
    assign pop        = !halt && !pipe_valid && !fifo_empty;
    assign push_entry = '{rd: fp_rd, data: fp_data};

    wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .head       (head),
        .count      (count),
        .slot_valid (slot_valid),
        .slot_rd    (slot_rd)
    );

    // Pending mask: every register some buffered FP result will still write.
    always_comb begin
        fp_pending_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (slot_valid[i]) begin
                fp_pending_mask = fp_pending_mask | rd_onehot(slot_rd[i]);
            end
        end
    end

    // Write port: pipeline first, then FIFO head, then bypass; idle drives zeros.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            register_write_enable <= 1'b0;
            destination_register  <= '0;
            value_to_write_to_reg <= '0;
        end else begin
            register_write_enable <= 1'b0;
            destination_register  <= '0;
            value_to_write_to_reg <= '0;
            if (!halt) begin
                if (pipe_valid) begin
                    if (pipe_rd != 5'd0) begin
                        register_write_enable <= 1'b1;
                        destination_register  <= pipe_rd;
                        value_to_write_to_reg <= pipe_data;
                    end
                end else if (pop) begin
                    register_write_enable <= 1'b1;
                    destination_register  <= head.rd;
                    value_to_write_to_reg <= head.data;
                end else if (bypass) begin
                    register_write_enable <= 1'b1;
                    destination_register  <= fp_rd;
                    value_to_write_to_reg <= fp_data;
                end
            end
        end
    end

    // Starvation counter: counts cycles the head sits unpopped, saturating.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt <= '0;
        end else if (fifo_empty || pop) begin
            wait_cnt <= '0;
        end else if (wait_cnt != 8'(MAX_WAIT)) begin
            wait_cnt <= wait_cnt + 8'd1;
        end
    end

    assign wb_stall_req = (wait_cnt == 8'(MAX_WAIT)) && !halt;

    // Sticky error: pipeline write during halt, or pipeline write racing a buffered FP write.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wb_waw_error <= 1'b0;
        end else if (pipe_valid &&
                     (halt || ((pipe_rd != 5'd0) && fp_pending_mask[pipe_rd]))) begin
            wb_waw_error <= 1'b1;
        end
    end

endmodule
